renode_outputs: RTL

- Reverse-direction counterpart of the co-simulation input sampler: watches HDL-driven output lines and reports every change to Renode as an interrupt-style message.
- Sits between the DUT's GPIO/IRQ outputs and the connection layer's outbound message path.
- Buffers change snapshots in a small FIFO and serializes them into one message per changed line.
- Sender side is a valid/ready handshake.

---
 rtl/renode_outputs_pkg.sv | 29 ++
 rtl/renode_outputs_fifo.sv | 63 ++++++
 rtl/renode_outputs.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/renode_outputs_pkg.sv
// renode_outputs_pkg: shared types and constants for the Renode output-line reporter.
// Optional macro RENODE_OUTPUTS_TIMESTAMP_EN adds a 32-bit timestamp to each snapshot.
package renode_outputs_pkg;

  typedef logic [7:0]  msg_action_t;
  typedef logic [63:0] msg_address_t;
  typedef logic [63:0] msg_data_t;

  // Matches the "interrupt" entry of the Renode co-simulation action enumeration.
  localparam msg_action_t ActionInterrupt = 8'd6;

  localparam int MaxOutputs     = 64;
  localparam int TimestampWidth = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Widest form of a snapshot; unused upper line bits stay zero.
  typedef struct packed {
    logic [MaxOutputs-1:0]     changed;
    logic [MaxOutputs-1:0]     values;
`ifdef RENODE_OUTPUTS_TIMESTAMP_EN
    logic [TimestampWidth-1:0] timestamp;
`endif
  } snapshot_t;

endpackage

// File: rtl/renode_outputs_fifo.sv
// renode_outputs_fifo: single-clock synchronous FIFO with full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
module renode_outputs_fifo
  import renode_outputs_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AddrWidth = $clog2(Depth);

  logic [Width-1:0]     mem [Depth];
  logic [AddrWidth-1:0] wr_ptr;
  logic [AddrWidth-1:0] rd_ptr;
  logic [AddrWidth:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign full  = (count == (AddrWidth + 1)'(Depth));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Qualify requests: pops need data, pushes need room or a simultaneous pop.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AddrWidth'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AddrWidth'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AddrWidth + 1)'(1);
        2'b01:   count <= count - (AddrWidth + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/renode_outputs.sv
// renode_outputs: watches DUT output lines and emits one interrupt message per
// changed line to Renode over a valid/ready handshake.
// Optional macro RENODE_OUTPUTS_TIMESTAMP_EN places a cycle timestamp in msg_data[63:32].
module renode_outputs
  import renode_outputs_pkg::*;
#(
  parameter int OutputsCount   = 1,
  parameter int FifoDepth      = 4,
  parameter int DropCountWidth = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [OutputsCount-1:0]   outputs,
  output logic                      msg_valid,
  input  logic                      msg_ready,
  output logic [7:0]                msg_action,
  output logic [63:0]               msg_address,
  output logic [63:0]               msg_data,
  output logic                      overflow,
  output logic [DropCountWidth-1:0] drop_count,
  input  logic                      clear_overflow
);

`ifdef RENODE_OUTPUTS_TIMESTAMP_EN
  localparam int SnapWidth = 2 * OutputsCount + TimestampWidth;
`else
  localparam int SnapWidth = 2 * OutputsCount;
`endif

  // Index of the lowest set bit; lower indices are reported first.
  function automatic logic [5:0] lowest_set(input logic [63:0] v);
    logic [5:0] idx;
    idx = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) begin
        idx = 6'(i);
      end
    end
    return idx;
  endfunction

  logic [OutputsCount-1:0] in_q;
  logic [OutputsCount-1:0] prev;
  logic                    armed;
  logic [OutputsCount-1:0] changed;
  logic                    push;
  logic                    pop;
  logic                    drop;
  logic [SnapWidth-1:0]    fifo_din;
  logic [SnapWidth-1:0]    fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  snapshot_t               head;
  snapshot_t               cur;
  snapshot_t               next_cur;
  state_t                  state;
  state_t                  next_state;
  logic                    load;
  logic [5:0]              idx;
  logic [5:0]              next_idx;
  logic [63:0]             cleared;

  assign changed = armed ? (in_q ^ prev) : '0;
  assign push    = |changed;
  assign drop    = push & fifo_full & ~pop;

`ifdef RENODE_OUTPUTS_TIMESTAMP_EN
  logic [TimestampWidth-1:0] ts_cnt;

  // Free-running cycle counter used to stamp each snapshot at its push edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TimestampWidth'(1);
    end
  end

  assign fifo_din = {ts_cnt, changed, in_q};
`else
  assign fifo_din = {changed, in_q};
`endif

  // Input register plus change-detection baseline; the arming edge loads the
  // live value as the baseline so the reset value of in_q never looks like a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= '0;
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      in_q <= outputs;
      if (!armed) begin
        prev  <= outputs;
        armed <= 1'b1;
      end else begin
        prev <= in_q;
      end
    end
  end

  renode_outputs_fifo #(
    .Width (SnapWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Widen the FIFO head into the common snapshot layout.
  always_comb begin
    head = '0;
    head.values[OutputsCount-1:0]  = fifo_dout[OutputsCount-1:0];
    head.changed[OutputsCount-1:0] = fifo_dout[2*OutputsCount-1:OutputsCount];
`ifdef RENODE_OUTPUTS_TIMESTAMP_EN
    head.timestamp = fifo_dout[SnapWidth-1 -: TimestampWidth];
`endif
  end

  // Serializer next-state: walk the pending bits of one snapshot, then fetch the next.
  always_comb begin
    idx        = lowest_set(cur.changed);
    cleared    = cur.changed & ~(64'd1 << idx);
    pop        = 1'b0;
    load       = 1'b0;
    next_cur   = cur;
    next_state = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          load       = 1'b1;
          next_cur   = head;
          next_state = SEND;
        end else begin
          next_state = IDLE;
        end
      end
      SEND: begin
        if (msg_valid && msg_ready) begin
          if (cleared != 64'd0) begin
            load             = 1'b1;
            next_cur.changed = cleared;
          end else if (!fifo_empty) begin
            pop      = 1'b1;
            load     = 1'b1;
            next_cur = head;
          end else begin
            next_cur.changed = 64'd0;
            next_state       = IDLE;
          end
        end else begin
          next_state = SEND;
        end
      end
      default: begin
        next_cur   = '0;
        next_state = IDLE;
      end
    endcase
    next_idx = lowest_set(next_cur.changed);
  end

  // Serializer state and registered message outputs; outputs only move on a
  // new message or on return to idle, so they hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur         <= '0;
      msg_valid   <= 1'b0;
      msg_action  <= 8'd0;
      msg_address <= 64'd0;
      msg_data    <= 64'd0;
    end else begin
      state <= next_state;
      cur   <= next_cur;
      if (load) begin
        msg_valid   <= 1'b1;
        msg_action  <= ActionInterrupt;
        msg_address <= {58'd0, next_idx};
`ifdef RENODE_OUTPUTS_TIMESTAMP_EN
        msg_data    <= {next_cur.timestamp, 31'd0, next_cur.values[next_idx]};
`else
        msg_data    <= {63'd0, next_cur.values[next_idx]};
`endif
      end else if (next_state == IDLE) begin
        msg_valid   <= 1'b0;
        msg_action  <= 8'd0;
        msg_address <= 64'd0;
        msg_data    <= 64'd0;
      end else begin
        msg_valid <= msg_valid;
      end
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow) begin
        drop_count <= DropCountWidth'(1);
      end else if (drop_count != {DropCountWidth{1'b1}}) begin
        drop_count <= drop_count + DropCountWidth'(1);
      end else begin
        drop_count <= drop_count;
      end
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow <= overflow;
    end
  end

endmodule
